sgdmac_wr_engine: RTL and testbench
===================================

// Module: sgdmac_wr_engine
// PURPOSE
//  Drain side of the SGDMAC data FIFO. Pops words from the FIFO's first-word-fall-through read port.
//  Emits them as AXI INCR write bursts (AW/W/B) to a destination buffer, one command at a time.
//  Sits between the FIFO read port and the DMAC AXI write master; one instance per channel.
// PARAMETERS
//  DATA_WIDTH     32   FIFO word / AXI WDATA width; one beat = DATA_WIDTH/8 bytes.
//  ADDR_WIDTH     32   AXI address width.
//  LEN_WIDTH      16   Byte-length field width.
//  MAX_BURST_LEN  16   Max beats per burst, 1..16; AWLEN = beats-1.
// PORTS
//  clk            in   1              Clock, rising edge.
//  rst_n          in   1              Asynchronous active-low reset.
//  start_i        in   1              Command strobe; sampled only in IDLE.
//  dst_addr_i     in   ADDR_WIDTH     Destination byte address; low log2(DATA_WIDTH/8) bits forced to 0.
//  byte_len_i     in   LEN_WIDTH      Bytes to write; low log2(DATA_WIDTH/8) bits ignored (round down).
//  busy_o         out  1              High from start accept until done.
//  done_o         out  1              One-cycle pulse when the last B response is accepted.
//  err_o          out  1              Sticky: some BRESP != OKAY since last start; cleared on start.
//  fifo_empty_i   in   1              FIFO empty flag.
//  fifo_rdata_i   in   DATA_WIDTH     FIFO head word, valid when !fifo_empty_i.
//  fifo_rden_o    out  1              FIFO pop.
//  awvalid_o/awready_i  out/in  1     AW handshake.
//  awaddr_o       out  ADDR_WIDTH     Burst start address.
//  awlen_o        out  4              Beats-1.
//  awsize_o       out  3              log2(DATA_WIDTH/8), constant.
//  awburst_o      out  2              2'b01 (INCR), constant.
//  wvalid_o/wready_i    out/in  1     W handshake.
//  wdata_o        out  DATA_WIDTH     = fifo_rdata_i.
//  wstrb_o        out  DATA_WIDTH/8   All ones.
//  wlast_o        out  1              High on the final beat of each burst.
//  bvalid_i/bready_o    in/out  1     B handshake.
//  bresp_i        in   2              Write response.
// BEHAVIOUR
//  FSM IDLE -> AW -> W -> B -> (AW | IDLE).
//  Reset (async): state=IDLE; busy_o, done_o, err_o, awvalid_o, wvalid_o, bready_o, fifo_rden_o = 0;
//   address and remaining-beat counters = 0.
//  IDLE, start_i=1:
//   - latch addr and beats = byte_len_i/(DATA_WIDTH/8); clear err_o; busy_o=1 next cycle.
//   - beats==0: done_o pulses the next cycle and the FSM stays in IDLE.
//  AW: burst = min(MAX_BURST_LEN, remaining, (4096 - addr[11:0]) / bytes-per-beat).
//   - bursts never cross a 4 KB boundary.
//   - awvalid_o=1; awaddr_o and awlen_o are registered and stable until awready_i.
//   - handshake -> W.
//  W: no W beat issues before its AW handshake completes.
//   - wvalid_o = !fifo_empty_i (combinational); fifo_rden_o = wvalid_o & wready_i.
//   - The beat counter decrements per handshake; wlast_o = (beat counter == 1).
//   - FIFO empty mid-burst: wvalid_o drops; the burst resumes when data returns (no timeout).
//   - Last-beat handshake -> B; addr += burst*bytes-per-beat; remaining -= burst.
//  B: bready_o=1.
//   - On bvalid_i, bresp_i!=2'b00 sets err_o. Transfer continues; no early abort.
//   - remaining!=0 -> AW; else done_o=1 for one cycle, busy_o=0, -> IDLE.
//  Only one outstanding burst at a time (AW, W and B are serialised).
//  start_i while busy is ignored.
//  Reset mid-transfer aborts immediately: no done_o, partial bursts abandoned.
//   The FIFO is reset by the same rst_n.
//  Counter widths: remaining = LEN_WIDTH bits; beat counter = 5 bits; address wraps modulo 2^ADDR_WIDTH.
// STRUCTURE
//  sgdmac_pkg: wr_state_t enum, AXI_BURST_INCR, AXI_RESP_OKAY, and a burst_beats() function (min/4 KB calc).
//  No sub-module: one FSM plus three counters.
//  Outputs are registered except wvalid_o, fifo_rden_o, wdata_o, which are combinational from FIFO flags.
// TESTING
//  1. addr 0x1000, len 64, FIFO prefilled with 16 words, ready always high.
//     -> one AW (awlen 15, addr 0x1000), 16 W beats with wlast on beat 16, done_o pulse, err_o=0.
//  2. addr 0x1FF0, len 64 -> two bursts: 0x1FF0 awlen 3, then 0x2000 awlen 11 (4 KB split); data order preserved.
//  3. len 100 (25 beats), FIFO fed 1 word per 3 cycles, wready toggling.
//     -> bursts 16+9; wvalid low while empty; no pop without handshake.
//  4. bresp=2'b10 on the first of two bursts -> second burst still issued, err_o=1 at done;
//     next start clears err_o.
//  5. len 0 -> done_o the cycle after start, no AW. len 3 -> same (rounds down to 0 beats).
//  6. rst_n asserted mid-W -> all outputs 0 asynchronously, no done_o.
//     A new start after reset completes normally.

Source files
------------

// File: rtl/sgdmac_pkg.sv
// Shared types and helpers for the SGDMAC write engine.
// burst_beats() sizes one AXI INCR burst so it never crosses a 4 KB page.
package sgdmac_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AW   = 2'd1,
    WR_W    = 2'd2,
    WR_B    = 2'd3
  } wr_state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] PAGE_BYTES     = 32'd4096;

  // Beats in the next burst: min(max_burst, remaining, beats left in the 4 KB page).
  function automatic logic [4:0] burst_beats(input logic [31:0] remaining,
                                             input logic [11:0] addr_lo,
                                             input int unsigned beat_log2,
                                             input int unsigned max_burst);
    logic [31:0] page_beats;
    logic [31:0] beats;
    page_beats = (PAGE_BYTES - {20'd0, addr_lo}) >> beat_log2;
    beats      = 32'(max_burst);
    if (remaining < beats) beats = remaining;
    if (page_beats < beats) beats = page_beats;
    return beats[4:0];
  endfunction

endpackage

// File: rtl/sgdmac_wr_engine.sv
// Drains the SGDMAC data FIFO into serialised AXI INCR write bursts (AW, then W, then B).
// state_o exposes the FSM state for debug and checkers.
module sgdmac_wr_engine
  import sgdmac_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
  input  logic [LEN_WIDTH-1:0]    byte_len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  input  logic                    fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]   fifo_rdata_i,
  output logic                    fifo_rden_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [3:0]              awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wlast_o,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  input  logic [1:0]              bresp_i,
  output logic [1:0]              state_o
);

  // Handshakes: a transfer occurs on a rising clk edge where valid and ready are both
  // high; a valid, once raised, holds its payload stable until that edge.

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BEAT_LOG2  = $clog2(BEAT_BYTES);

  wr_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [4:0]            beat_cnt_q, beat_cnt_d;
  logic [3:0]            awlen_q, awlen_d;
  logic                  awvalid_q, awvalid_d;
  logic                  bready_q, bready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [LEN_WIDTH-1:0]  start_beats;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [LEN_WIDTH-1:0]  burst_len;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic [4:0]            next_burst;
  logic                  load_burst;
  logic                  w_fire;

  assign start_beats = byte_len_i >> BEAT_LOG2;
  assign start_addr  = dst_addr_i & ~ADDR_WIDTH'(BEAT_BYTES - 1);
  assign burst_len   = LEN_WIDTH'(awlen_q) + LEN_WIDTH'(1);
  assign burst_bytes = (ADDR_WIDTH'(awlen_q) + ADDR_WIDTH'(1)) << BEAT_LOG2;

  assign wvalid_o    = (state_q == WR_W) && !fifo_empty_i;
  assign w_fire      = wvalid_o && wready_i;
  assign fifo_rden_o = w_fire;
  assign wdata_o     = fifo_rdata_i;
  assign wstrb_o     = '1;
  assign wlast_o     = (state_q == WR_W) && (beat_cnt_q == 5'd1);

  assign awvalid_o   = awvalid_q;
  assign awaddr_o    = addr_q;
  assign awlen_o     = awlen_q;
  assign awsize_o    = 3'(BEAT_LOG2);
  assign awburst_o   = AXI_BURST_INCR;
  assign bready_o    = bready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    awlen_d     = awlen_q;
    awvalid_d   = awvalid_q;
    bready_d    = bready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    load_burst  = 1'b0;

    unique case (state_q)
      WR_IDLE: begin
        if (start_i) begin
          addr_d      = start_addr;
          remaining_d = start_beats;
          err_d       = 1'b0;
          if (start_beats == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d     = 1'b1;
            state_d    = WR_AW;
            load_burst = 1'b1;
          end
        end
      end
      WR_AW: begin
        if (awready_i) begin
          awvalid_d = 1'b0;
          state_d   = WR_W;
        end
      end
      WR_W: begin
        if (w_fire) begin
          beat_cnt_d = beat_cnt_q - 5'd1;
          if (beat_cnt_q == 5'd1) begin
            state_d     = WR_B;
            bready_d    = 1'b1;
            addr_d      = addr_q + burst_bytes;
            remaining_d = remaining_q - burst_len;
          end
        end
      end
      WR_B: begin
        if (bvalid_i) begin
          bready_d = 1'b0;
          if (bresp_i != AXI_RESP_OKAY) err_d = 1'b1;
          if (remaining_q != '0) begin
            state_d    = WR_AW;
            load_burst = 1'b1;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = WR_IDLE;
          end
        end
      end
      default: state_d = WR_IDLE;
    endcase

    // Size the next burst from the already-updated address and remaining count.
    next_burst = burst_beats(32'(remaining_d), addr_d[11:0], BEAT_LOG2, MAX_BURST_LEN);
    if (load_burst) begin
      awlen_d    = 4'(next_burst - 5'd1);
      beat_cnt_d = next_burst;
      awvalid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WR_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      awlen_q     <= awlen_d;
      awvalid_q   <= awvalid_d;
      bready_q    <= bready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_sgdmac_wr_engine.sv
// Directed bench for sgdmac_wr_engine: FIFO model, AXI slave responder, burst/beat monitor.
module tb_sgdmac_wr_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] byte_len_i = '0;
  logic        busy_o, done_o, err_o;
  logic        fifo_empty_i;
  logic [31:0] fifo_rdata_i;
  logic        fifo_rden_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [31:0] awaddr_o;
  logic [3:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        wvalid_o;
  logic        wready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o;
  logic        bvalid_i = 1'b0;
  logic        bready_o;
  logic [1:0]  bresp_i = 2'b00;
  logic [1:0]  state_o;

  sgdmac_wr_engine dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .dst_addr_i(dst_addr_i),
    .byte_len_i(byte_len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i), .fifo_rden_o(fifo_rden_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
    .awsize_o(awsize_o), .awburst_o(awburst_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .bvalid_i(bvalid_i),
    .bready_o(bready_o), .bresp_i(bresp_i), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  logic [31:0] fifo_mem [256];
  logic [7:0]  wr_ptr = '0;
  logic [7:0]  rd_ptr;
  int          word_seq = 0;

  assign fifo_empty_i = (rd_ptr == wr_ptr);
  assign fifo_rdata_i = fifo_mem[rd_ptr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ptr <= '0;
    else if (fifo_rden_o) rd_ptr <= rd_ptr + 8'd1;
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_w_q[$];
  logic        exp_last_q[$];
  logic [31:0] exp_aw_addr_q[$];
  logic [3:0]  exp_aw_len_q[$];
  logic [31:0] act_w_q[$];
  logic        act_last_q[$];
  logic [31:0] act_aw_addr_q[$];
  logic [3:0]  act_aw_len_q[$];
  int          done_cnt = 0;
  int          b_cnt = 0;
  int          viol_w_before_aw = 0;
  int          viol_pop = 0;
  int          viol_wvalid_empty = 0;
  logic        aw_open = 1'b0;
  logic        wready_toggle = 1'b0;
  int          err_burst = -1;

  // ---------------- AXI slave responder ----------------
  always @(negedge clk) begin
    awready_i = 1'b1;
    wready_i  = wready_toggle ? ~wready_i : 1'b1;
    bvalid_i  = bready_o;
    bresp_i   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    if (!rst_n) begin
      aw_open = 1'b0;
    end else begin
      if (awvalid_o && awready_i) begin
        act_aw_addr_q.push_back(awaddr_o);
        act_aw_len_q.push_back(awlen_o);
        aw_open = 1'b1;
      end
      if (wvalid_o && wready_i) begin
        if (!aw_open) viol_w_before_aw++;
        act_w_q.push_back(wdata_o);
        act_last_q.push_back(wlast_o);
        if (wlast_o) aw_open = 1'b0;
      end
      if (fifo_rden_o && !(wvalid_o && wready_i)) viol_pop++;
      if (wvalid_o && fifo_empty_i) viol_wvalid_empty++;
      if (bvalid_i && bready_o) b_cnt++;
      if (done_o) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word();
    logic [31:0] w;
    w = (32'(word_seq) * 32'h0101_0101) ^ 32'hC0DE_0000;
    word_seq++;
    fifo_mem[wr_ptr] = w;
    exp_w_q.push_back(w);
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic clear_sb();
    exp_w_q.delete(); exp_last_q.delete(); exp_aw_addr_q.delete(); exp_aw_len_q.delete();
    act_w_q.delete(); act_last_q.delete(); act_aw_addr_q.delete(); act_aw_len_q.delete();
  endtask

  task automatic add_burst(input logic [31:0] a, input logic [3:0] l);
    exp_aw_addr_q.push_back(a);
    exp_aw_len_q.push_back(l);
    for (int k = 0; k <= int'(l); k++) exp_last_q.push_back(k == int'(l));
  endtask

  // Runs one command; expected bursts must already be queued with add_burst().
  task automatic run_xfer(input string name, input logic [31:0] addr, input logic [15:0] len,
                          input int nbeats, input bit slow, input bit exp_err);
    int d0;
    int cyc;
    d0 = done_cnt;
    b_cnt = 0;
    viol_w_before_aw = 0; viol_pop = 0; viol_wvalid_empty = 0;
    if (!slow) begin
      for (int i = 0; i < nbeats; i++) push_word();
    end else begin
      fork
        begin
          for (int i = 0; i < nbeats; i++) begin
            push_word();
            repeat (3) @(negedge clk);
          end
        end
      join_none
    end
    @(negedge clk);
    start_i = 1'b1; dst_addr_i = addr; byte_len_i = len;
    @(negedge clk);
    // A second strobe while busy must be ignored.
    start_i = 1'b1; dst_addr_i = 32'hDEAD_0000; byte_len_i = 16'd4;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy_o);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL %s err_cleared_on_start: got %b want 0", name, err_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (done_cnt == d0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++; $display("FAIL %s done_timeout: got no done within %0d cycles", name, cyc);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL %s busy_after_done: got %b want 0", name, busy_o);
    end
    checks++;
    if (err_o !== exp_err) begin
      errors++; $display("FAIL %s err_at_done: got %b want %b", name, err_o, exp_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - d0);
    end
    checks++;
    if (act_aw_addr_q.size() !== exp_aw_addr_q.size()) begin
      errors++; $display("FAIL %s aw_count: got %0d want %0d", name, act_aw_addr_q.size(), exp_aw_addr_q.size());
    end else begin
      foreach (exp_aw_addr_q[i]) begin
        checks++;
        if (act_aw_addr_q[i] !== exp_aw_addr_q[i] || act_aw_len_q[i] !== exp_aw_len_q[i]) begin
          errors++;
          $display("FAIL %s aw[%0d]: got addr %h len %0d want addr %h len %0d", name, i,
                   act_aw_addr_q[i], act_aw_len_q[i], exp_aw_addr_q[i], exp_aw_len_q[i]);
        end
      end
    end
    checks++;
    if (act_w_q.size() !== exp_w_q.size()) begin
      errors++; $display("FAIL %s w_count: got %0d want %0d", name, act_w_q.size(), exp_w_q.size());
    end else begin
      foreach (exp_w_q[i]) begin
        checks++;
        if (act_w_q[i] !== exp_w_q[i] || act_last_q[i] !== exp_last_q[i]) begin
          errors++;
          $display("FAIL %s w[%0d]: got data %h last %b want data %h last %b", name, i,
                   act_w_q[i], act_last_q[i], exp_w_q[i], exp_last_q[i]);
        end
      end
    end
    checks++;
    if (viol_w_before_aw + viol_pop + viol_wvalid_empty !== 0) begin
      errors++;
      $display("FAIL %s protocol: w_before_aw %0d pop_no_hs %0d wvalid_empty %0d want 0", name,
               viol_w_before_aw, viol_pop, viol_wvalid_empty);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, err_o, awvalid_o, wvalid_o, bready_o, fifo_rden_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy %b done %b err %b awv %b wv %b brdy %b rden %b want all 0",
               busy_o, done_o, err_o, awvalid_o, wvalid_o, bready_o, fifo_rden_o);
    end
    checks++;
    if (awaddr_o !== 32'h0 || awlen_o !== 4'h0 || state_o !== 2'd0) begin
      errors++; $display("FAIL reset_regs: got addr %h len %0d state %0d want 0 0 0", awaddr_o, awlen_o, state_o);
    end
    checks++;
    if (awsize_o !== 3'd2 || awburst_o !== 2'b01 || wstrb_o !== 4'hF) begin
      errors++; $display("FAIL const_fields: got size %0d burst %b strb %h want 2 01 f", awsize_o, awburst_o, wstrb_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    clear_sb(); wready_toggle = 1'b0; err_burst = -1;
    add_burst(32'h0000_1000, 4'd15);
    run_xfer("single_burst", 32'h0000_1000, 16'd64, 16, 1'b0, 1'b0);
  endtask

  task automatic test_4k_split();
    clear_sb(); wready_toggle = 1'b0; err_burst = -1;
    add_burst(32'h0000_1FF0, 4'd3);
    add_burst(32'h0000_2000, 4'd11);
    run_xfer("4k_split", 32'h0000_1FF0, 16'd64, 16, 1'b0, 1'b0);
  endtask

  task automatic test_slow_fifo();
    clear_sb(); wready_toggle = 1'b1; err_burst = -1;
    add_burst(32'h0000_3000, 4'd15);
    add_burst(32'h0000_3040, 4'd8);
    run_xfer("slow_fifo", 32'h0000_3000, 16'd100, 25, 1'b1, 1'b0);
    wready_toggle = 1'b0;
  endtask

  task automatic test_bresp_err();
    clear_sb(); err_burst = 0;
    add_burst(32'h0000_4000, 4'd15);
    add_burst(32'h0000_4040, 4'd3);
    run_xfer("bresp_err", 32'h0000_4000, 16'd80, 20, 1'b0, 1'b1);
    // Unaligned address is forced down to a word boundary; the earlier error is cleared.
    clear_sb(); err_burst = -1;
    add_burst(32'h0000_5000, 4'd1);
    run_xfer("err_clear", 32'h0000_5002, 16'd8, 2, 1'b0, 1'b0);
  endtask

  task automatic test_zero_len(input logic [15:0] len);
    int d0;
    int aw0;
    d0 = done_cnt;
    aw0 = act_aw_addr_q.size();
    @(negedge clk);
    start_i = 1'b1; dst_addr_i = 32'h0000_7000; byte_len_i = len;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || awvalid_o !== 1'b0) begin
      errors++; $display("FAIL zero_len_%0d: got done %b busy %b awv %b want 1 0 0", len, done_o, busy_o, awvalid_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || state_o !== 2'd0) begin
      errors++; $display("FAIL zero_len_%0d_pulse: got done %b state %0d want 0 0", len, done_o, state_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1 || act_aw_addr_q.size() !== aw0) begin
      errors++; $display("FAIL zero_len_%0d_count: got done %0d aw %0d want 1 0", len, done_cnt - d0, act_aw_addr_q.size() - aw0);
    end
  endtask

  task automatic test_reset_mid_w();
    int d0;
    int cyc;
    clear_sb(); err_burst = -1; wready_toggle = 1'b0;
    for (int i = 0; i < 16; i++) push_word();
    @(negedge clk);
    start_i = 1'b1; dst_addr_i = 32'h0000_0000; byte_len_i = 16'd64;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (act_w_q.size() < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (act_w_q.size() < 5) begin
      errors++; $display("FAIL reset_mid_w_progress: got %0d beats want >= 5", act_w_q.size());
    end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, awvalid_o, wvalid_o, bready_o, fifo_rden_o, wlast_o} !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid_w_outputs: got busy %b done %b err %b awv %b wv %b brdy %b rden %b last %b want all 0",
               busy_o, done_o, err_o, awvalid_o, wvalid_o, bready_o, fifo_rden_o, wlast_o);
    end
    wr_ptr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin
      errors++; $display("FAIL reset_mid_w_no_done: got %0d done pulses want 0", done_cnt - d0);
    end
    clear_sb();
    add_burst(32'h0000_6000, 4'd7);
    run_xfer("after_reset", 32'h0000_6000, 16'd32, 8, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_4k_split();
    test_slow_fifo();
    test_bresp_err();
    test_zero_len(16'd0);
    test_zero_len(16'd3);
    test_reset_mid_w();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
